// File: rtl/hyper_pkg.sv
// ---------------------------------------------------------------------------
// hyper_pkg
// Shared definitions for the HyperBus target emulator:
//   - hyper_state_e : transaction FSM states
//   - CA_*          : bit positions of the 48-bit command/address word
//   - CA_EDGES      : number of hyper clock edges that carry the CA word
//   - ca_word_addr  : extracts the 16-bit word address from a CA word
// ---------------------------------------------------------------------------
package hyper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CA    = 3'd1,
    ST_LAT   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } hyper_state_e;

  localparam int CA_RW_BIT  = 47;  // 1 = read
  localparam int CA_AS_BIT  = 46;  // 1 = register space
  localparam int CA_BT_BIT  = 45;  // burst type, ignored (always linear)
  localparam int CA_ROW_MSB = 44;
  localparam int CA_ROW_LSB = 16;
  localparam int CA_COL_MSB = 2;
  localparam int CA_COL_LSB = 0;

  localparam int CA_EDGES = 6;

  // Word address is the row field followed by the low column bits.
  function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
    return {ca[CA_ROW_MSB:CA_ROW_LSB], ca[CA_COL_MSB:CA_COL_LSB]};
  endfunction

endpackage

// File: rtl/hyper_target_sync.sv
// ---------------------------------------------------------------------------
// hyper_target_sync
// Two-flop synchronizer for the HyperBus pad inputs plus hyper clock edge
// detection. All inputs share the same two stages so data and clock stay
// aligned after synchronization.
// Ports:
//   sys_clk_i, rstn_i : oversampling clock, async active-low reset
//   cs_n_i, ck_i, dq_i, rwds_i : raw pad inputs
//   cs_n_o, dq_o, rwds_o       : stage-2 (synchronized) values
//   edge_o : hyper clock changed (stage2 != stage3)
//   rise_o : the detected edge is a rising edge
// ---------------------------------------------------------------------------
module hyper_target_sync (
  input  logic       sys_clk_i,
  input  logic       rstn_i,
  input  logic       cs_n_i,
  input  logic       ck_i,
  input  logic [7:0] dq_i,
  input  logic       rwds_i,
  output logic       cs_n_o,
  output logic [7:0] dq_o,
  output logic       rwds_o,
  output logic       edge_o,
  output logic       rise_o
);

  // Lane packing: {cs_n, ck, rwds, dq[7:0]}
  localparam int          W       = 11;
  localparam int          CK_BIT  = 9;
  // chip select resets deasserted so reset release never looks like a start
  localparam logic [W-1:0] RST_VAL = {1'b1, 10'b0};

  logic [W-1:0] w_in;
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic         r_ck_s3;

  assign w_in = {cs_n_i, ck_i, rwds_i, dq_i};

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1    <= RST_VAL;
      r_s2    <= RST_VAL;
      r_ck_s3 <= 1'b0;
    end else begin
      r_s1    <= w_in;
      r_s2    <= r_s1;
      r_ck_s3 <= r_s2[CK_BIT];
    end
  end

  assign cs_n_o = r_s2[10];
  assign rwds_o = r_s2[8];
  assign dq_o   = r_s2[7:0];
  assign edge_o = r_s2[CK_BIT] ^ r_ck_s3;
  assign rise_o = r_s2[CK_BIT];

endmodule

// File: rtl/hyper_target_emu.sv
// ---------------------------------------------------------------------------
// hyper_target_emu
// HyperBus memory-side responder for emulation. Oversamples the controller's
// hyper clock, decodes the 48-bit CA word, waits a fixed 2*LATENCY edges and
// then serves linear 16-bit read/write bursts from an internal memory.
// Register-space reads return ID_WORD; register-space writes are dropped.
// Ports:
//   sys_clk_i, rstn_i  : oversampling clock (>= 4x hyper clock), async reset
//   hyper_cs_ni        : chip select, active low
//   hyper_ck_i         : hyper clock
//   hyper_dq_i         : DQ from controller
//   hyper_rwds_i       : write byte mask from controller
//   hyper_dq_o/_oe_o   : read data and its output enable
//   hyper_rwds_o/_oe_o : read strobe / latency indication and its enable
//   txn_done_o         : one-cycle pulse at the end of a transaction
//   txn_read_o         : direction of the last finished transaction
// ---------------------------------------------------------------------------
module hyper_target_emu #(
  parameter int          MEM_DEPTH = 256,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] ID_WORD   = 16'h0C81
) (
  input  logic       sys_clk_i,
  input  logic       rstn_i,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic [7:0] hyper_dq_i,
  input  logic       hyper_rwds_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o,
  output logic       txn_done_o,
  output logic       txn_read_o
);

  import hyper_pkg::*;

  localparam int         AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [4:0] CA_LAST  = 5'(CA_EDGES - 1);
  localparam logic [4:0] LAT_LAST = 5'(2 * LATENCY - 1);

  // synchronized inputs
  logic       w_cs_n;
  logic [7:0] w_dq;
  logic       w_rwds;
  logic       w_edge;
  logic       w_rise;

  hyper_target_sync u_sync (
    .sys_clk_i (sys_clk_i),
    .rstn_i    (rstn_i),
    .cs_n_i    (hyper_cs_ni),
    .ck_i      (hyper_ck_i),
    .dq_i      (hyper_dq_i),
    .rwds_i    (hyper_rwds_i),
    .cs_n_o    (w_cs_n),
    .dq_o      (w_dq),
    .rwds_o    (w_rwds),
    .edge_o    (w_edge),
    .rise_o    (w_rise)
  );

  // state
  hyper_state_e r_state, r_state_next;
  logic [4:0]   r_edge_cnt, r_edge_cnt_next;
  logic [39:0]  r_ca, r_ca_next;
  logic [AW-1:0] r_addr, r_addr_next;
  logic         r_is_read, r_is_read_next;
  logic         r_is_reg, r_is_reg_next;
  logic [7:0]   r_wr_hi, r_wr_hi_next;
  logic         r_wr_hi_mask, r_wr_hi_mask_next;
  logic         r_wr_hi_vld, r_wr_hi_vld_next;
  logic [7:0]   r_dq_o, r_dq_o_next;
  logic         r_rwds_o, r_rwds_o_next;
  logic         r_dq_oe, r_dq_oe_next;
  logic         r_rwds_oe, r_rwds_oe_next;
  logic         r_txn_done, r_txn_done_next;
  logic         r_txn_read, r_txn_read_next;

  // memory
  logic [15:0]  r_mem [MEM_DEPTH];
  logic [15:0]  r_mem_q;
  logic         w_mem_we;
  logic [1:0]   w_mem_be;
  logic [15:0]  w_mem_wdata;

  logic [47:0]  w_ca_full;
  logic [15:0]  w_rd_word;

  // CA word as it will look once the current byte is shifted in
  assign w_ca_full = {r_ca, w_dq};
  assign w_rd_word = r_is_reg ? ID_WORD : r_mem_q;

  always_comb begin
    r_state_next      = r_state;
    r_edge_cnt_next   = r_edge_cnt;
    r_ca_next         = r_ca;
    r_addr_next       = r_addr;
    r_is_read_next    = r_is_read;
    r_is_reg_next     = r_is_reg;
    r_wr_hi_next      = r_wr_hi;
    r_wr_hi_mask_next = r_wr_hi_mask;
    r_wr_hi_vld_next  = r_wr_hi_vld;
    r_dq_o_next       = r_dq_o;
    r_rwds_o_next     = r_rwds_o;
    r_txn_done_next   = 1'b0;
    r_txn_read_next   = r_txn_read;
    w_mem_we          = 1'b0;
    w_mem_be          = 2'b00;
    w_mem_wdata       = {r_wr_hi, w_dq};

    if (r_state != ST_IDLE && w_cs_n) begin
      // CS release wins over any edge seen in the same cycle
      r_state_next = ST_IDLE;
      if (r_state != ST_CA) begin
        r_txn_done_next = 1'b1;
        r_txn_read_next = r_is_read;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_cs_n) begin
            r_state_next    = ST_CA;
            r_edge_cnt_next = '0;
          end
        end

        ST_CA: begin
          if (w_edge) begin
            r_ca_next       = w_ca_full[39:0];
            r_edge_cnt_next = r_edge_cnt + 5'd1;
            if (r_edge_cnt == CA_LAST) begin
              r_state_next    = ST_LAT;
              r_edge_cnt_next = '0;
              r_addr_next     = AW'(ca_word_addr(w_ca_full));
              r_is_read_next  = w_ca_full[CA_RW_BIT];
              r_is_reg_next   = w_ca_full[CA_AS_BIT];
            end
          end
        end

        ST_LAT: begin
          // r_mem_q follows r_addr, so the first read word is already
          // loaded by the time the first data edge arrives.
          if (w_edge) begin
            r_edge_cnt_next = r_edge_cnt + 5'd1;
            if (r_edge_cnt == LAT_LAST) begin
              r_state_next     = r_is_read ? ST_RDATA : ST_WDATA;
              r_edge_cnt_next  = '0;
              r_wr_hi_vld_next = 1'b0;
            end
          end
        end

        ST_WDATA: begin
          if (w_edge) begin
            if (w_rise) begin
              r_wr_hi_next      = w_dq;
              r_wr_hi_mask_next = w_rwds;
              r_wr_hi_vld_next  = 1'b1;
            end else begin
              if (r_wr_hi_vld) begin
                w_mem_we    = !r_is_reg;
                w_mem_be    = {~r_wr_hi_mask, ~w_rwds};
                r_addr_next = r_addr + AW'(1);
              end
              r_wr_hi_vld_next = 1'b0;
            end
          end
        end

        ST_RDATA: begin
          if (w_edge) begin
            r_rwds_o_next = ~r_rwds_o;
            if (w_rise) begin
              r_dq_o_next = w_rd_word[15:8];
            end else begin
              r_dq_o_next = w_rd_word[7:0];
              r_addr_next = r_addr + AW'(1);
            end
          end
        end

        default: r_state_next = ST_IDLE;
      endcase
    end

    // read outputs idle low whenever we are not (or no longer) in RDATA
    if (r_state_next != ST_RDATA) begin
      r_dq_o_next   = 8'h00;
      r_rwds_o_next = 1'b0;
    end
    r_dq_oe_next   = (r_state_next == ST_RDATA);
    r_rwds_oe_next = (r_state_next == ST_CA) || (r_state_next == ST_LAT) ||
                     (r_state_next == ST_RDATA);
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_edge_cnt   <= '0;
      r_ca         <= '0;
      r_addr       <= '0;
      r_is_read    <= 1'b0;
      r_is_reg     <= 1'b0;
      r_wr_hi      <= '0;
      r_wr_hi_mask <= 1'b0;
      r_wr_hi_vld  <= 1'b0;
      r_dq_o       <= '0;
      r_rwds_o     <= 1'b0;
      r_dq_oe      <= 1'b0;
      r_rwds_oe    <= 1'b0;
      r_txn_done   <= 1'b0;
      r_txn_read   <= 1'b0;
    end else begin
      r_state      <= r_state_next;
      r_edge_cnt   <= r_edge_cnt_next;
      r_ca         <= r_ca_next;
      r_addr       <= r_addr_next;
      r_is_read    <= r_is_read_next;
      r_is_reg     <= r_is_reg_next;
      r_wr_hi      <= r_wr_hi_next;
      r_wr_hi_mask <= r_wr_hi_mask_next;
      r_wr_hi_vld  <= r_wr_hi_vld_next;
      r_dq_o       <= r_dq_o_next;
      r_rwds_o     <= r_rwds_o_next;
      r_dq_oe      <= r_dq_oe_next;
      r_rwds_oe    <= r_rwds_oe_next;
      r_txn_done   <= r_txn_done_next;
      r_txn_read   <= r_txn_read_next;
    end
  end

  // Byte-enabled memory with registered read; contents are not reset.
  always_ff @(posedge sys_clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < 2; b++) begin
        if (w_mem_be[b]) begin
          r_mem[r_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
        end
      end
    end
    r_mem_q <= r_mem[r_addr];
  end

  assign hyper_dq_o      = r_dq_o;
  assign hyper_dq_oe_o   = r_dq_oe;
  assign hyper_rwds_o    = r_rwds_o;
  assign hyper_rwds_oe_o = r_rwds_oe;
  assign txn_done_o      = r_txn_done;
  assign txn_read_o      = r_txn_read;

endmodule

// File: tb/tb_hyper_target_emu.sv
// ---------------------------------------------------------------------------
// tb_hyper_target_emu
// Directed bench for hyper_target_emu: acts as the HyperBus controller,
// driving CS/CK/DQ/RWDS with the hyper clock at 1/8 of sys_clk_i, and checks
// read data, RWDS toggling, output enables and transaction reporting.
// ---------------------------------------------------------------------------
module tb_hyper_target_emu;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 6;
  localparam logic [15:0] IDW   = 16'h0C81;

  logic       sys_clk_i    = 1'b0;
  logic       rstn_i       = 1'b0;
  logic       hyper_cs_ni  = 1'b1;
  logic       hyper_ck_i   = 1'b0;
  logic [7:0] hyper_dq_i   = 8'h00;
  logic       hyper_rwds_i = 1'b0;
  logic [7:0] hyper_dq_o;
  logic       hyper_dq_oe_o;
  logic       hyper_rwds_o;
  logic       hyper_rwds_oe_o;
  logic       txn_done_o;
  logic       txn_read_o;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  logic [15:0] wr_data [8];
  logic [1:0]  wr_mask [8];   // bit1 masks upper byte, bit0 lower byte
  logic [15:0] rd_data [8];

  hyper_target_emu #(
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT),
    .ID_WORD   (IDW)
  ) dut (
    .sys_clk_i       (sys_clk_i),
    .rstn_i          (rstn_i),
    .hyper_cs_ni     (hyper_cs_ni),
    .hyper_ck_i      (hyper_ck_i),
    .hyper_dq_i      (hyper_dq_i),
    .hyper_rwds_i    (hyper_rwds_i),
    .hyper_dq_o      (hyper_dq_o),
    .hyper_dq_oe_o   (hyper_dq_oe_o),
    .hyper_rwds_o    (hyper_rwds_o),
    .hyper_rwds_oe_o (hyper_rwds_oe_o),
    .txn_done_o      (txn_done_o),
    .txn_read_o      (txn_read_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // counts every cycle txn_done_o is high, so a stretched pulse shows up too
  always @(negedge sys_clk_i) if (txn_done_o) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // one hyper clock edge carrying byte d with mask m; returns once the
  // target's registered response to that edge is visible
  task automatic edge_tx(input logic [7:0] d, input logic m);
    hyper_dq_i   = d;
    hyper_rwds_i = m;
    @(negedge sys_clk_i);
    hyper_ck_i = ~hyper_ck_i;
    repeat (3) @(negedge sys_clk_i);
  endtask

  task automatic do_txn(input logic rd, input logic rs, input logic [31:0] a,
                        input int nbytes, input int ca_bytes, input logic rst_mid);
    logic [47:0] ca;
    logic [7:0]  b8;
    logic [15:0] w16;
    ca        = '0;
    ca[47]    = rd;
    ca[46]    = rs;
    ca[45]    = 1'b1;
    ca[44:16] = a[31:3];
    ca[2:0]   = a[2:0];
    hyper_cs_ni = 1'b0;
    repeat (4) @(negedge sys_clk_i);
    for (int i = 0; i < ca_bytes; i++) begin
      b8 = ca[47-8*i -: 8];
      edge_tx(b8, 1'b0);
    end
    if (ca_bytes == 6) begin
      for (int i = 0; i < 2*LAT; i++) begin
        edge_tx(8'h00, 1'b0);
        if (i == 0) begin
          check("lat_rwds_oe", {31'd0, hyper_rwds_oe_o}, 32'd1);
          check("lat_rwds_o",  {31'd0, hyper_rwds_o},    32'd0);
        end
      end
      for (int b = 0; b < nbytes; b++) begin
        if (rd) begin
          edge_tx(8'h00, 1'b0);
          if (b == 0) check("rd_dq_oe", {31'd0, hyper_dq_oe_o}, 32'd1);
          check($sformatf("rd_rwds[%0d]", b), {31'd0, hyper_rwds_o},
                (b % 2 == 0) ? 32'd1 : 32'd0);
          if (b % 2 == 0) rd_data[b/2][15:8] = hyper_dq_o;
          else            rd_data[b/2][7:0]  = hyper_dq_o;
        end else begin
          w16 = wr_data[b/2];
          if (b % 2 == 0) edge_tx(w16[15:8], wr_mask[b/2][1]);
          else            edge_tx(w16[7:0],  wr_mask[b/2][0]);
        end
      end
    end
    if (rst_mid) begin
      rstn_i = 1'b0;
      #1;
      check("rst_dq_oe",   {31'd0, hyper_dq_oe_o},   32'd0);
      check("rst_rwds_oe", {31'd0, hyper_rwds_oe_o}, 32'd0);
    end
    hyper_cs_ni  = 1'b1;
    hyper_dq_i   = 8'h00;
    hyper_rwds_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    hyper_ck_i = 1'b0;
    repeat (8) @(negedge sys_clk_i);
    if (rst_mid) begin
      rstn_i = 1'b1;
      repeat (4) @(negedge sys_clk_i);
    end
    $display("txn rd=%0d rs=%0d addr=%0h bytes=%0d ca=%0d rst=%0d done_cnt=%0d",
             rd, rs, a, nbytes, ca_bytes, rst_mid, done_cnt);
  endtask

  task automatic wr(input logic [31:0] a, input int nwords);
    do_txn(1'b0, 1'b0, a, 2*nwords, 6, 1'b0);
  endtask

  task automatic rdm(input logic [31:0] a, input int nwords);
    do_txn(1'b1, 1'b0, a, 2*nwords, 6, 1'b0);
  endtask

  initial begin
    int d0;
    foreach (wr_mask[i]) wr_mask[i] = 2'b00;
    foreach (wr_data[i]) wr_data[i] = 16'h0000;
    foreach (rd_data[i]) rd_data[i] = 16'h0000;

    // reset state
    repeat (4) @(negedge sys_clk_i);
    check("rst_dq_o",    {24'd0, hyper_dq_o},        32'd0);
    check("rst_dq_oe0",  {31'd0, hyper_dq_oe_o},     32'd0);
    check("rst_rwds_o",  {31'd0, hyper_rwds_o},      32'd0);
    check("rst_rwds_oe0",{31'd0, hyper_rwds_oe_o},   32'd0);
    check("rst_done",    {31'd0, txn_done_o},        32'd0);
    check("rst_read",    {31'd0, txn_read_o},        32'd0);
    rstn_i = 1'b1;
    repeat (4) @(negedge sys_clk_i);

    // write 4 words at 0x10, read them back
    wr_data[0] = 16'h1111; wr_data[1] = 16'h2222;
    wr_data[2] = 16'h3333; wr_data[3] = 16'h4444;
    d0 = done_cnt;
    wr(32'h10, 4);
    check("wr_done",  done_cnt - d0, 32'd1);
    check("wr_dir",   {31'd0, txn_read_o}, 32'd0);
    d0 = done_cnt;
    rdm(32'h10, 4);
    check("rd_w0", {16'd0, rd_data[0]}, 32'h1111);
    check("rd_w1", {16'd0, rd_data[1]}, 32'h2222);
    check("rd_w2", {16'd0, rd_data[2]}, 32'h3333);
    check("rd_w3", {16'd0, rd_data[3]}, 32'h4444);
    check("rd_done", done_cnt - d0, 32'd1);
    check("rd_dir",  {31'd0, txn_read_o}, 32'd1);
    check("idle_dq_oe", {31'd0, hyper_dq_oe_o}, 32'd0);

    // byte mask: lower byte masked over 0x5555
    wr_data[0] = 16'h5555;
    wr(32'h20, 1);
    wr_data[0] = 16'hABCD; wr_mask[0] = 2'b01;
    wr(32'h20, 1);
    wr_mask[0] = 2'b00;
    rdm(32'h20, 1);
    check("mask_rd", {16'd0, rd_data[0]}, 32'hAB55);

    // register space: reads give ID, writes are dropped
    do_txn(1'b1, 1'b1, 32'h10, 6, 6, 1'b0);
    check("reg_w0", {16'd0, rd_data[0]}, {16'd0, IDW});
    check("reg_w1", {16'd0, rd_data[1]}, {16'd0, IDW});
    check("reg_w2", {16'd0, rd_data[2]}, {16'd0, IDW});
    wr_data[0] = 16'hDEAD;
    do_txn(1'b0, 1'b1, 32'h10, 2, 6, 1'b0);
    rdm(32'h10, 1);
    check("reg_mem_kept", {16'd0, rd_data[0]}, 32'h1111);

    // address wrap at the top of memory
    wr_data[0] = 16'hAAAA; wr_data[1] = 16'hBBBB;
    wr(32'd255, 2);
    rdm(32'd255, 1);
    check("wrap_255", {16'd0, rd_data[0]}, 32'hAAAA);
    rdm(32'd0, 1);
    check("wrap_0", {16'd0, rd_data[0]}, 32'hBBBB);
    rdm(32'd255, 2);
    check("wrap_burst0", {16'd0, rd_data[0]}, 32'hAAAA);
    check("wrap_burst1", {16'd0, rd_data[1]}, 32'hBBBB);

    // CS abort after upper byte of the second word
    wr_data[0] = 16'h0000; wr_data[1] = 16'h0000;
    wr(32'h30, 2);
    wr_data[0] = 16'h1234; wr_data[1] = 16'h5678;
    d0 = done_cnt;
    do_txn(1'b0, 1'b0, 32'h30, 3, 6, 1'b0);
    check("abort_done", done_cnt - d0, 32'd1);
    rdm(32'h30, 2);
    check("abort_w0", {16'd0, rd_data[0]}, 32'h1234);
    check("abort_w1", {16'd0, rd_data[1]}, 32'h0000);

    // CS abort during CA: no completion reported, target still usable
    d0 = done_cnt;
    do_txn(1'b1, 1'b0, 32'h10, 0, 3, 1'b0);
    check("ca_abort_done", done_cnt - d0, 32'd0);
    rdm(32'h10, 1);
    check("after_ca_abort", {16'd0, rd_data[0]}, 32'h1111);

    // reset in the middle of a read, then a clean read
    do_txn(1'b1, 1'b0, 32'h10, 3, 6, 1'b1);
    check("post_rst_dir", {31'd0, txn_read_o}, 32'd0);
    rdm(32'h10, 4);
    check("post_rst_w0", {16'd0, rd_data[0]}, 32'h1111);
    check("post_rst_w1", {16'd0, rd_data[1]}, 32'h2222);
    check("post_rst_w2", {16'd0, rd_data[2]}, 32'h3333);
    check("post_rst_w3", {16'd0, rd_data[3]}, 32'h4444);
    check("post_rst_rddir", {31'd0, txn_read_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
